down_counter_timer: RTL
=======================

Name: down_counter_timer

Overview:
Loadable down-counter and timer. It is the count-down counterpart of the team's loadable 4-bit up-counter with carry-out.
- Takes a parallel preset and decrements it while enabled.
- Flags terminal count with a combinational borrow (for cascading stages) and a registered one-cycle Done pulse.
- Used as a delay or interval timer next to the up-counter blocks.

Parameters:
WIDTH, 4, width of the preset, the count register and the reload register.

Ports:
CLK  input  1  clock, positive-edge sensitive
Clear_b  input  1  reset, asynchronous, active-low
Data_in  input  WIDTH  parallel preset value
Load  input  1  active high; loads Data_in into the count and reload registers
Count  input  1  active high; decrement enable, also the borrow-in from a lower stage
A_count  output  WIDTH  current count (registered)
B_out  output  1  borrow-out, combinational
Done  output  1  one-cycle expiry pulse (registered)
Busy  output  1  high while in state COUNT (registered)

Behaviour:
Interface (already decided):
- One clock, CLK; all state changes on the posedge of CLK.
- Reset Clear_b is asynchronous and active-low.

Reset (Clear_b=0, immediate, independent of CLK):
- A_count=0, reload register=0, state=IDLE.
- Done=0, Busy=0. B_out is therefore 0.
- Reset asserted mid-count aborts the run. No Done pulse is produced.

States:
- IDLE: Count is ignored; A_count holds its value.
- COUNT: running; Busy=1.

Load (highest priority below reset, accepted in any state):
- A_count<=Data_in and reload<=Data_in.
- If Data_in!=0, next state is COUNT; if Data_in==0, next state is IDLE.
- Load never produces Done, including the case where Load coincides with terminal count.

COUNT state, Load=0:
- Count=0: hold A_count.
- Count=1 and A_count>1: A_count<=A_count-1 (modulo 2^WIDTH; no wrap can occur, since the state is left at 1).
- Count=1 and A_count==1 (terminal):
  - Base build: A_count<=0, next state IDLE.
  - Done=1 on the following cycle only.

B_out:
- B_out = (state==COUNT) & Count & (A_count==1) & ~Load.
- Same-cycle, combinational. Intended to drive the Count input of the next-higher stage.

Done:
- Registered, asserted for exactly one cycle after each terminal transition, otherwise 0.
- Busy drops in the same cycle that Done rises (base build).

Latency:
- Load at edge k gives A_count=Data_in after edge k.
- With Count held high, a preset of N gives a terminal transition at edge k+N and Done high in the cycle after edge k+N.

Optional Feature:
Macro: DCNT_AUTO_RELOAD_EN.
- Defined: at terminal count, A_count<=reload and the state stays COUNT; Done still pulses; Busy stays 1. Gives a periodic Done every N enabled cycles.
- Undefined: one-shot behaviour as above (A_count<=0, state IDLE).
- In both builds, a reload value of 0 can never enter COUNT, because Load with Data_in==0 goes to IDLE.

Test Plan:
All scenarios with WIDTH=4.
1. Reset then Load: Clear_b=0 mid-run → A_count=0, Busy=0, Done=0 immediately, before any clock edge. Then Data_in=4'b1010, Load=1 for 1 cycle → A_count=10, Busy=1.
2. Count down: after loading 10, Count=1 continuously.
   - A_count steps 9,8,...,1,0.
   - B_out=1 only in the cycle where A_count==1.
   - Done=1 for exactly one cycle after 0 is reached.
   - Busy=0 afterwards; A_count stays 0 in IDLE with Count=1.
3. Pause: load 5; Count pattern 1,0,0,1 → A_count 4,4,4,3; no Done.
4. Load collision: load 3, count to 1, then Load=1 with Data_in=7 and Count=1 together → A_count=7, B_out=0, no Done pulse.
5. Zero and mid-run reset:
   - Load Data_in=0 → state IDLE, Busy=0, no Done.
   - Load 6, count twice, pulse Clear_b low → A_count=0 asynchronously, no Done.
6. DCNT_AUTO_RELOAD_EN build: load 3, Count=1 for 10 cycles.
   - A_count sequence 2,1,3,2,1,3,...
   - Done pulses every 3 cycles; Busy stays 1.

Source files
------------

// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer with combinational borrow-out and registered Done pulse.
// Define DCNT_AUTO_RELOAD_EN to reload the preset at terminal count (periodic timer).
module down_counter_timer #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             Clear_b,
    input  logic [WIDTH-1:0] Data_in,
    input  logic             Load,
    input  logic             Count,
    output logic [WIDTH-1:0] A_count,
    output logic             B_out,
    output logic             Done,
    output logic             Busy
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_COUNT = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             done_q, done_d;
    logic             terminal;

    // Load suppresses terminal so a colliding reload never borrows or fires Done
    assign terminal = (state_q == S_COUNT) & Count & (cnt_q == ONE) & ~Load;

    assign A_count = cnt_q;
    assign B_out   = terminal;
    assign Done    = done_q;
    assign Busy    = (state_q == S_COUNT);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        if (Load) begin
            cnt_d    = Data_in;
            reload_d = Data_in;
            state_d  = (Data_in != '0) ? S_COUNT : S_IDLE;
        end else if (terminal) begin
            done_d = 1'b1;
`ifdef DCNT_AUTO_RELOAD_EN
            cnt_d   = reload_q;
            state_d = S_COUNT;
`else
            cnt_d   = '0;
            state_d = S_IDLE;
`endif
        end else if ((state_q == S_COUNT) && Count) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge CLK or negedge Clear_b) begin
        if (!Clear_b) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

endmodule
